score_digit_driver: RTL
=======================

Name: score_digit_driver

Overview:
- Keeps the player's score for the memory game as a two-digit BCD count.
- Produces the 4-bit digit codes consumed by the two binary-to-7-segment decoder instances: tens display and ones display.
- Blanks the tens digit when it is a leading zero.
- Blinks both digits while the game is over.
- Blank is signalled by digit code 4'hF, which the decoder renders as all segments off.

Parameters:
- CLKS_PER_BLINK, 12500000: i_Clk cycles per blink half-period (0.5 s at 25 MHz). Legal range is >= 2.
- MAX_SCORE, 99: saturation score in decimal. Legal range is 1..99. Split internally into MAX_TENS = MAX_SCORE/10 and MAX_ONES = MAX_SCORE%10.

Ports:
- i_Clk, input, 1: system clock; all state is updated on the rising edge.
- i_Rst, input, 1: asynchronous, active-high reset.
- i_Score_Inc, input, 1: single-cycle increment pulse from the game FSM.
- i_Score_Clr, input, 1: synchronous clear of the score to 00.
- i_Game_Over, input, 1: level signal; while high, the display blinks and the score is frozen.
- o_Ones, output, 4: ones digit code, 0..9, or 4'hF for blank.
- o_Tens, output, 4: tens digit code, 1..9, or 4'hF for blank.
- o_Max, output, 1: high while the score equals MAX_SCORE.

Behaviour:
- Reset (async assert, i_Rst high):
  - Internal state: r_Ones=0, r_Tens=0, blink counter=0, blink phase=ON.
  - Outputs: o_Ones=4'h0, o_Tens=4'hF, o_Max=0.
  - Reset mid-count or mid-blink returns immediately to these values.
- Priority at each edge: i_Score_Clr, then i_Game_Over freeze, then i_Score_Inc.
- Clear: r_Ones=0 and r_Tens=0.
  - Allowed during game over; the display then blinks "0" (tens blanked).
- Increment, taken when i_Score_Inc=1, i_Game_Over=0, i_Score_Clr=0, and score != MAX_SCORE:
  - If r_Ones==9: r_Ones=0 and r_Tens=r_Tens+1.
  - Otherwise: r_Ones=r_Ones+1.
- Saturation: when {r_Tens,r_Ones} == {MAX_TENS,MAX_ONES}, increments are ignored and there is no wrap.
- Width rule: r_Ones and r_Tens never hold values 10..15.
- Inc held high for k cycles counts k times; the pulse is not edge-detected.
- Blink counter: runs only while i_Game_Over=1.
  - Counts 0..CLKS_PER_BLINK-1.
  - At terminal count it wraps to 0 and toggles the blink phase.
- i_Game_Over=0: counter is held at 0 and phase is forced ON.
  - Consequence: every game-over entry starts with the digits visible for a full half-period.
- Output register: o_Ones, o_Tens and o_Max are registered from the current state.
  - A pulse sampled at edge N updates the state at edge N.
  - The outputs reflect it at edge N+1: one cycle of output latency.
- Output decode, in priority order:
  - Phase OFF (only possible when i_Game_Over=1): o_Ones=4'hF, o_Tens=4'hF.
  - Else if r_Tens==0: o_Tens=4'hF (leading-zero blank), o_Ones=r_Ones.
  - Else: o_Tens=r_Tens, o_Ones=r_Ones.
- o_Max: registered compare of the state against MAX_SCORE; not affected by blinking.
- Game-over deassert: on the next edge, phase is ON and the digits are shown steadily.
- Simultaneous clear and increment: clear wins, result is 00 and the increment is lost.

Test Plan (sim with CLKS_PER_BLINK=4, MAX_SCORE=12 unless noted):
- Reset, then 5 Inc pulses -> o_Tens=F, o_Ones=5, one cycle after the last pulse; o_Max=0.
- 12 Inc pulses from 0 -> o_Ones runs 1..9, then 0 with o_Tens=1, then ends at tens=1/ones=2 with o_Max=1; 3 further pulses leave 12.
- MAX_SCORE=99: 99 pulses then 1 more -> output stays 9/9 with o_Max=1; never 00.
- Score 7, i_Game_Over=1 for 20 cycles -> o_Ones alternates 7/F every 4 cycles starting with 7; o_Tens=F throughout; Inc pulses ignored; after deassert the output is steady 7.
- Inc and Clr in the same cycle at score 11 -> next output F/0, o_Max=0.
- i_Rst asserted asynchronously between edges during blink phase OFF -> outputs read F/0 immediately, before the next edge; o_Max=0.

Source files
------------

// File: rtl/score_digit_driver.sv
// Two-digit BCD score keeper for the memory game, producing 7-segment digit
// codes with leading-zero blanking and a game-over blink.
module score_digit_driver #(
  parameter int CLKS_PER_BLINK = 12500000,
  parameter int MAX_SCORE      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Score_Inc,
  input  logic       i_Score_Clr,
  input  logic       i_Game_Over,
  output logic [3:0] o_Ones,
  output logic [3:0] o_Tens,
  output logic       o_Max
);

  localparam int              CNT_W    = (CLKS_PER_BLINK > 2) ? $clog2(CLKS_PER_BLINK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BLINK - 1);
  localparam logic [3:0]      MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0]      MAX_ONES = 4'(MAX_SCORE % 10);
  localparam logic [3:0]      BLANK    = 4'hF;

  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase_on;
  logic             at_max;

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  // Score state: clear beats the game-over freeze, which beats increment.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (i_Score_Clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (!i_Game_Over && i_Score_Inc && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  // Blink timer restarts visible on every game-over entry.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!i_Game_Over) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt <= '0;
      phase_on  <= !phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Output register decodes the current state, giving one cycle of latency.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Ones <= 4'h0;
      o_Tens <= BLANK;
      o_Max  <= 1'b0;
    end else begin
      o_Max <= at_max;
      if (!phase_on) begin
        o_Ones <= BLANK;
        o_Tens <= BLANK;
      end else if (tens == 4'd0) begin
        o_Ones <= ones;
        o_Tens <= BLANK;
      end else begin
        o_Ones <= ones;
        o_Tens <= tens;
      end
    end
  end

endmodule
